genius_playback_ctrl: RTL and testbench
=======================================

GENIUS_PLAYBACK_CTRL -- requirements
Module: genius_playback_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002 clk_i  in  1  system clock, 50 MHz; all logic on its rising edge.
REQ-003 rst_i  in  1  synchronous reset, active-high.
REQ-004 clk_1, clk_2, clk_3, clk_5  in  1 each  divided-clock levels from the game clock divider; sampled as data, never used as clocks.
REQ-005 level_i  in  2  speed select: 0 = clk_1, 1 = clk_2, 2 = clk_3, 3 = clk_5.
REQ-006 start_i  in  1  request to play a sequence; level-sensitive, evaluated in IDLE only.
REQ-007 abort_i  in  1  stop playback immediately.
REQ-008 seq_len_i  in  5  number of steps to play, 1..31.
REQ-009 mem_data_i  in  2  colour code at mem_addr_o; asynchronous read, valid in the same cycle.
REQ-010 mem_addr_o  out  5  index of the current step.
REQ-011 led_o  out  4  one-hot colour LEDs: code 0 -> bit 0, ..., code 3 -> bit 3.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 done_o  out  1  one-cycle pulse when a sequence completes normally.

Function
REQ-014 SHALL register the previous value of all four clk_x inputs every cycle; tick = rising edge (prev 0, now 1) of the clock selected by the latched level.
REQ-015 SHALL latch level_i and seq_len_i on the cycle that start is accepted; later changes SHALL have no effect until the next start.
REQ-016 SHALL implement the states IDLE, PRE, SHOW, GAP, and FIN.
REQ-017 IDLE with start_i=1 and seq_len_i!=0 SHALL move to PRE next cycle, set mem_addr_o=0, and assert busy_o.
REQ-018 IDLE with start_i=1 and seq_len_i=0 SHALL stay in IDLE, with no busy_o and no done_o.
REQ-019 PRE: led_o=0; on tick SHALL move to SHOW and load led_o with one-hot(mem_data_i) in the same edge.
REQ-020 SHOW: led_o SHALL hold the value loaded on entry; on tick SHALL move to GAP and set led_o=0.
REQ-021 GAP: led_o=0; on tick, if mem_addr_o==len-1, SHALL move to FIN, otherwise SHALL increment mem_addr_o and move to SHOW, loading led_o from mem_data_i at the new address.
REQ-022 SHALL arrange the transitions so that the new-address read is valid one cycle before the SHOW load: increment mem_addr_o on the GAP tick and load led_o on the first SHOW cycle. In this ordering SHOW lasts from that load until the next tick.
REQ-023 FIN SHALL assert done_o for exactly one cycle, then return to IDLE; busy_o SHALL be high in FIN.
REQ-024 Each step SHALL take exactly 2 ticks (SHOW + GAP); total playback = 1 + 2*len ticks after start.
REQ-025 abort_i=1 in any non-IDLE state SHALL return to IDLE next cycle with led_o=0, mem_addr_o=0, busy_o=0, and done_o not asserted; abort SHALL override a coincident tick.
REQ-026 start_i while busy_o=1 SHALL be ignored; start_i and abort_i together in IDLE SHALL be treated as abort (no start).
REQ-027 A selected clock that is already high at start SHALL NOT produce a tick until its next 0->1 transition.
REQ-028 Ticks from unselected clocks SHALL be ignored.
REQ-029 mem_addr_o SHALL never exceed len-1; no wrap-around.

Reset
REQ-030 rst_i=1 on a clock edge SHALL force IDLE, led_o=0, mem_addr_o=0, busy_o=0, done_o=0, all prev-clock registers=0, and latched level/len=0.
REQ-031 Reset mid-playback SHALL behave like REQ-030, with no done_o pulse.
REQ-032 After reset release, start SHALL be accepted on the first cycle.

Verification
REQ-033 Normal playback: level=3, clk_5 toggling every 10 cycles, len=3, memory {2,0,3}, pulse start -> led_o sequence 0000, 0100, 0000, 0001, 0000, 1000, 0000, then done_o one cycle; busy_o low after FIN.
REQ-034 Speed select: level=0 with clk_1 toggling every 500 cycles and len=1 -> done_o 3 ticks (approx. 3000 cycles) after start; clk_5 edges cause no state change.
REQ-035 Abort coincident with a SHOW->GAP tick -> IDLE next cycle, led_o=0, mem_addr_o=0, done_o never asserted.
REQ-036 Zero length: start with len=0 -> busy_o stays 0, done_o stays 0.
REQ-037 Mid-run changes: change level_i and seq_len_i, and pulse start_i again, during playback -> original speed and length are kept, and exactly one done_o is produced.
REQ-038 Reset during GAP of step 2 with len=5 -> all outputs 0 next cycle; a new start then plays from address 0.

Source files
------------

// File: rtl/genius_playback_ctrl.sv
// Plays a stored colour sequence on one-hot LEDs, paced by rising edges of a
// selectable divided game clock that is sampled as ordinary data.
`timescale 1ns/1ps
module genius_playback_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_1,
  input  logic       clk_2,
  input  logic       clk_3,
  input  logic       clk_5,
  input  logic [1:0] level_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [4:0] seq_len_i,
  input  logic [1:0] mem_data_i,
  output logic [4:0] mem_addr_o,
  output logic [3:0] led_o,
  output logic       busy_o,
  output logic       done_o
);

  // state | meaning
  // IDLE  | waiting for a start request
  // PRE   | lead-in tick before the first step, LEDs dark
  // SHOW  | current colour lit
  // GAP   | LEDs dark between steps
  // FIN   | one-cycle completion pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SHOW = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] clk_now, clk_prev;
  logic [1:0] level_q;
  logic [4:0] len_q;
  logic [4:0] addr_q;
  logic [3:0] led_q;
  logic       load_pend_q;
  logic       tick;
  logic       start_ok;
  logic       last_step;

  function automatic logic [3:0] onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  assign clk_now   = {clk_5, clk_3, clk_2, clk_1};
  assign tick      = clk_now[level_q] & ~clk_prev[level_q];
  assign start_ok  = start_i & ~abort_i & (seq_len_i != 5'd0);
  assign last_step = (addr_q == (len_q - 5'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = PRE;
      PRE: begin
        if (abort_i)   state_d = IDLE;
        else if (tick) state_d = SHOW;
      end
      SHOW: begin
        if (abort_i)   state_d = IDLE;
        else if (tick) state_d = GAP;
      end
      GAP: begin
        if (abort_i)   state_d = IDLE;
        else if (tick) state_d = last_step ? FIN : SHOW;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = 1'b0;
    led_o  = 4'b0000;
    case (state_q)
      SHOW:    led_o  = led_q;
      FIN:     done_o = ~abort_i;
      default: ;
    endcase
  end

  assign mem_addr_o = addr_q;

  // After a GAP tick the address moves first; the colour is captured one
  // cycle later so the asynchronous memory read has settled on the new index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_prev    <= 4'b0000;
      level_q     <= 2'd0;
      len_q       <= 5'd0;
      addr_q      <= 5'd0;
      led_q       <= 4'b0000;
      load_pend_q <= 1'b0;
    end else begin
      clk_prev <= clk_now;
      case (state_q)
        IDLE: begin
          led_q       <= 4'b0000;
          load_pend_q <= 1'b0;
          if (start_ok) begin
            level_q <= level_i;
            len_q   <= seq_len_i;
            addr_q  <= 5'd0;
          end
        end
        PRE: if (tick) led_q <= onehot(mem_data_i);
        SHOW: begin
          if (tick) begin
            led_q       <= 4'b0000;
            load_pend_q <= 1'b0;
          end else if (load_pend_q) begin
            led_q       <= onehot(mem_data_i);
            load_pend_q <= 1'b0;
          end
        end
        GAP: begin
          if (tick && !last_step) begin
            addr_q      <= addr_q + 5'd1;
            load_pend_q <= 1'b1;
          end
        end
        FIN:     addr_q <= 5'd0;
        default: ;
      endcase
      if (abort_i && (state_q != IDLE)) begin
        addr_q      <= 5'd0;
        led_q       <= 4'b0000;
        load_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_genius_playback_ctrl.sv
// Directed bench for genius_playback_ctrl: divided clocks are generated here,
// a monitor records LED changes, ticks and done pulses for comparison.
`timescale 1ns/1ps
module tb_genius_playback_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clk_1, clk_2, clk_3, clk_5;
  logic [1:0] level_i;
  logic       start_i;
  logic       abort_i;
  logic [4:0] seq_len_i;
  logic [1:0] mem_data_i;
  logic [4:0] mem_addr_o;
  logic [3:0] led_o;
  logic       busy_o;
  logic       done_o;

  logic [1:0] mem [32];
  assign mem_data_i = mem[mem_addr_o];

  genius_playback_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clk_1      (clk_1),
    .clk_2      (clk_2),
    .clk_3      (clk_3),
    .clk_5      (clk_5),
    .level_i    (level_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .seq_len_i  (seq_len_i),
    .mem_data_i (mem_data_i),
    .mem_addr_o (mem_addr_o),
    .led_o      (led_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #10 clk_i = ~clk_i;

  // divided clocks: half period hp[i] cycles, or held at hold[i] when hp[i]==0
  int         hp [4];
  int         gcnt [4];
  logic [3:0] hold = 4'b0000;
  logic [3:0] divclk = 4'b0000;

  always @(negedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (hp[i] == 0) begin
        divclk[i] = hold[i];
        gcnt[i]   = 0;
      end else if (gcnt[i] >= hp[i] - 1) begin
        gcnt[i]   = 0;
        divclk[i] = ~divclk[i];
      end else begin
        gcnt[i]++;
      end
    end
  end

  assign clk_1 = divclk[0];
  assign clk_2 = divclk[1];
  assign clk_3 = divclk[2];
  assign clk_5 = divclk[3];

  int         clr_req = 0;
  int         clr_ack = 0;
  int         mon_sel = 3;
  int         tick_cnt = 0;
  int         done_cnt = 0;
  int         done_long = 0;
  int         max_addr = 0;
  int         cyc = 0;
  logic [3:0] led_last = 4'b0000;
  logic [3:0] led_hist [$];
  logic [3:0] cur_clk;
  logic [3:0] prev_clk = 4'b0000;
  logic       prev_busy = 1'b0;
  logic       prev_done = 1'b0;

  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (clr_ack != clr_req) begin
      clr_ack   = clr_req;
      tick_cnt  = 0;
      done_cnt  = 0;
      done_long = 0;
      max_addr  = 0;
      led_hist.delete();
      led_last  = led_o;
    end
    cur_clk = {clk_5, clk_3, clk_2, clk_1};
    if (prev_busy && cur_clk[mon_sel] && !prev_clk[mon_sel]) tick_cnt++;
    if (done_o) done_cnt++;
    if (done_o && prev_done) done_long++;
    if (led_o != led_last) begin
      led_hist.push_back(led_o);
      led_last = led_o;
    end
    if (int'(mem_addr_o) > max_addr) max_addr = int'(mem_addr_o);
    prev_clk  = cur_clk;
    prev_busy = busy_o;
    prev_done = done_o;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic start_pulse(input logic [1:0] lv, input logic [4:0] ln);
    @(negedge clk_i);
    level_i   = lv;
    seq_len_i = ln;
    start_i   = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  // one manual rising edge on clk_5, optionally with abort on the same edge
  task automatic man_tick(input logic with_abort);
    @(posedge clk_i);
    #2;
    hold[3] = 1'b1;
    abort_i = with_abort;
    @(posedge clk_i);
    #2;
    hold[3] = 1'b0;
    abort_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_led [6];
  int         t0;
  int         el;

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    level_i   = 2'd0;
    seq_len_i = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 2'd0;
    for (int i = 0; i < 4; i++) hp[i] = 0;
    exp_led = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};

    // reset state
    cyc_n(3);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_led",  {28'd0, led_o}, 32'd0);
    chk("rst_addr", {27'd0, mem_addr_o}, 32'd0);

    // normal playback, clk_5, len 3, memory {2,0,3}, start right after reset release
    hp[0] = 3; hp[1] = 4; hp[2] = 7; hp[3] = 10;
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    mon_sel = 3;
    clr_req++;
    cyc_n(2);
    rst_i     = 1'b0;
    level_i   = 2'd3;
    seq_len_i = 5'd3;
    start_i   = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
    chk("t2_start_first_cycle", {31'd0, busy_o}, 32'd1);
    wait_idle("t2_timeout", 400);
    cyc_n(2);
    chk("t2_ticks", tick_cnt, 7);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_width", done_long, 0);
    chk("t2_led_changes", led_hist.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_led%0d", i), {28'd0, led_hist[i]}, {28'd0, exp_led[i]});
    chk("t2_max_addr", max_addr, 2);
    chk("t2_busy_after", {31'd0, busy_o}, 32'd0);

    // slow speed: clk_1 at 500-cycle half period, len 1
    hp[0] = 500;
    mon_sel = 0;
    mem[0] = 2'd1;
    clr_req++;
    t0 = cyc;
    start_pulse(2'd0, 5'd1);
    wait_idle("t3_timeout", 4000);
    el = cyc - t0;
    cyc_n(2);
    chk("t3_ticks", tick_cnt, 3);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_elapsed_in_range", {31'd0, (el >= 2000 && el <= 3010)}, 32'd1);

    // selected clock already high at start must not tick
    hp[0] = 3;
    mon_sel = 3;
    hold[3] = 1'b1;
    hp[3] = 0;
    mem[0] = 2'd2;
    cyc_n(3);
    clr_req++;
    start_pulse(2'd3, 5'd1);
    cyc_n(40);
    chk("t4_busy", {31'd0, busy_o}, 32'd1);
    chk("t4_led_dark", {28'd0, led_o}, 32'd0);
    chk("t4_addr", {27'd0, mem_addr_o}, 32'd0);
    hp[3] = 10;
    wait_idle("t4_timeout", 200);
    cyc_n(2);
    chk("t4_ticks", tick_cnt, 3);
    chk("t4_done_cnt", done_cnt, 1);

    // abort on the same edge as the SHOW->GAP tick
    hp[3] = 0;
    hold[3] = 1'b0;
    mem[0] = 2'd1; mem[1] = 2'd3;
    cyc_n(3);
    clr_req++;
    start_pulse(2'd3, 5'd2);
    man_tick(1'b0);
    chk("t5_show_led", {28'd0, led_o}, 32'h2);
    man_tick(1'b1);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_led", {28'd0, led_o}, 32'd0);
    chk("t5_addr", {27'd0, mem_addr_o}, 32'd0);
    cyc_n(5);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_still_idle", {31'd0, busy_o}, 32'd0);

    // zero length is refused
    clr_req++;
    start_pulse(2'd3, 5'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    cyc_n(3);
    chk("t6_busy_later", {31'd0, busy_o}, 32'd0);
    chk("t6_done_cnt", done_cnt, 0);

    // level/length changes and restart requests during playback are ignored
    hp[3] = 10;
    mem[0] = 2'd2; mem[1] = 2'd1;
    cyc_n(2);
    clr_req++;
    start_pulse(2'd3, 5'd2);
    cyc_n(25);
    level_i   = 2'd0;
    seq_len_i = 5'd5;
    start_i   = 1'b1;
    cyc_n(3);
    start_i   = 1'b0;
    wait_idle("t7_timeout", 400);
    cyc_n(2);
    chk("t7_ticks", tick_cnt, 5);
    chk("t7_done_cnt", done_cnt, 1);
    chk("t7_max_addr", max_addr, 1);

    // reset during GAP of step 2 with len 5, then replay from address 0
    hp[3] = 0;
    hold[3] = 1'b0;
    mem[0] = 2'd1; mem[1] = 2'd2;
    cyc_n(3);
    clr_req++;
    start_pulse(2'd3, 5'd5);
    man_tick(1'b0);
    man_tick(1'b0);
    man_tick(1'b0);
    chk("t8_step2_addr", {27'd0, mem_addr_o}, 32'd1);
    chk("t8_step2_led", {28'd0, led_o}, 32'h4);
    man_tick(1'b0);
    chk("t8_gap_led", {28'd0, led_o}, 32'd0);
    chk("t8_gap_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t8_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t8_rst_led", {28'd0, led_o}, 32'd0);
    chk("t8_rst_addr", {27'd0, mem_addr_o}, 32'd0);
    chk("t8_rst_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b0;
    cyc_n(2);
    chk("t8_no_done_pulse", done_cnt, 0);
    hp[3] = 10;
    clr_req++;
    start_pulse(2'd3, 5'd2);
    wait_idle("t8_timeout", 400);
    cyc_n(2);
    chk("t8_replay_first_led", {28'd0, led_hist[0]}, 32'h2);
    chk("t8_replay_done", done_cnt, 1);
    chk("t8_replay_max_addr", max_addr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
